// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access size,
// FSM state encoding and the alignment check.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // An access of 2^size bytes must start on a 2^size byte boundary.
  function automatic logic is_misaligned(input logic [2:0] offset, input size_e size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = offset[0];
      SZ_W:    mis = |offset[1:0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Load alignment: pulls 2^size bytes out of a doubleword at a byte offset
// and sign- or zero-extends them to 64 bits.
module load_align
  import dmem_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [63:0] value
);

  logic [63:0] shifted;

  assign shifted = dword >> {offset, 3'b000};

  always_comb begin
    value = shifted;
    case (size)
      SZ_B:    value = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
      SZ_H:    value = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_W:    value = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory interface: request/response handshakes,
// configurable wait, error check, read-modify-write stores and aligned loads.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  size_e       size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH_WORDS];

  // With no wait cycles the request executes on its own accept edge, so the
  // execution path reads the live inputs in IDLE and the captured copy later.
  logic          in_idle;
  logic          ex_write;
  logic [63:0]   ex_addr;
  size_e         ex_size;
  logic          ex_unsigned;
  logic [63:0]   ex_wdata;
  logic          ex_err;
  logic          exec_fire;
  logic [AW-1:0] ex_idx;
  logic [63:0]   old_dword;
  logic [63:0]   shifted_wdata;
  logic [63:0]   merged_dword;
  logic [63:0]   load_value;
  logic [3:0]    nbytes;
  logic [7:0]    byte_en;

  assign in_idle     = (state_q == ST_IDLE);
  assign ex_write    = in_idle ? req_write          : write_q;
  assign ex_addr     = in_idle ? req_addr           : addr_q;
  assign ex_size     = in_idle ? size_e'(req_size)  : size_q;
  assign ex_unsigned = in_idle ? req_unsigned       : unsigned_q;
  assign ex_wdata    = in_idle ? req_wdata          : wdata_q;

  assign exec_fire = (in_idle && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_q == ST_WAIT) && (wait_cnt_q == 4'd0));

  assign ex_err = is_misaligned(ex_addr[2:0], ex_size) ||
                  (ex_addr[63:3] >= 61'(DEPTH_WORDS));

  assign ex_idx        = ex_addr[3+AW-1:3];
  assign old_dword     = mem_q[ex_idx];
  assign shifted_wdata = ex_wdata << {ex_addr[2:0], 3'b000};
  assign nbytes        = 4'd1 << ex_size;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign byte_en[gi] = (4'(gi) >= {1'b0, ex_addr[2:0]}) &&
                           (4'(gi) <  ({1'b0, ex_addr[2:0]} + nbytes));
      assign merged_dword[gi*8 +: 8] = byte_en[gi] ? shifted_wdata[gi*8 +: 8]
                                                   : old_dword[gi*8 +: 8];
    end
  endgenerate

  load_align u_load_align (
    .dword       (old_dword),
    .offset      (ex_addr[2:0]),
    .size        (ex_size),
    .is_unsigned (ex_unsigned),
    .value       (load_value)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          addr_d     = req_addr;
          size_d     = size_e'(req_size);
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_RESP;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (exec_fire) begin
      rdata_d = (ex_err || ex_write) ? 64'd0 : load_value;
      err_d   = ex_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= 64'd0;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      wdata_q    <= 64'd0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately not reset; a reset on the commit edge cancels the store.
  always_ff @(posedge clk) begin
    if (!reset && exec_fire && ex_write && !ex_err) begin
      mem_q[ex_idx] <= merged_dword;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: one responder with WAIT_CYCLES=3 and one with WAIT_CYCLES=0,
// selected by sel and driven from a shared request bus.
module tb_data_mem_responder;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_ready = 1'b0;

  logic        r3_req_ready, r3_rsp_valid, r3_rsp_err;
  logic [63:0] r3_rsp_rdata;
  logic        r0_req_ready, r0_rsp_valid, r0_rsp_err;
  logic [63:0] r0_rsp_rdata;

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [63:0] o_rsp_rdata;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid & ~sel),
    .req_ready    (r3_req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (r3_rsp_valid),
    .rsp_ready    (rsp_ready & ~sel),
    .rsp_rdata    (r3_rsp_rdata),
    .rsp_err      (r3_rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid & sel),
    .req_ready    (r0_req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (r0_rsp_valid),
    .rsp_ready    (rsp_ready & sel),
    .rsp_rdata    (r0_rsp_rdata),
    .rsp_err      (r0_rsp_err)
  );

  assign o_req_ready = sel ? r0_req_ready : r3_req_ready;
  assign o_rsp_valid = sel ? r0_rsp_valid : r3_rsp_valid;
  assign o_rsp_rdata = sel ? r0_rsp_rdata : r3_rsp_rdata;
  assign o_rsp_err   = sel ? r0_rsp_err   : r3_rsp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected response, and return once accepted.
  task automatic start_req(input logic w, input logic [63:0] a, input logic [1:0] sz,
                           input logic u, input logic [63:0] wd,
                           input logic [63:0] er, input logic ee, output bit ok);
    int n;
    sb_q.push_back('{rdata: er, err: ee});
    @(negedge clk);
    req_write = w; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      void'(sb_q.pop_front());
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr = {$urandom, $urandom};
    req_size = ~sz;
    req_unsigned = ~u;
    req_wdata = {$urandom, $urandom};
    ok = 1'b1;
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall.
  task automatic finish_rsp(input int hold);
    int lat;
    int exp_lat;
    exp_t e;
    exp_lat = sel ? 1 : 4;
    lat = 1;
    while (!o_rsp_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rdata", o_rsp_rdata, e.rdata);
    chk("err", {63'd0, o_rsp_err}, {63'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {63'd0, o_rsp_valid}, 64'd1);
      chk("hold_rdata", o_rsp_rdata, e.rdata);
      chk("hold_req_ready", {63'd0, o_req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("idle_req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("idle_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    $display("[TB] txn dut=%0d latency=%0d rdata=%h err=%0d (expected %h err=%0d)",
             sel ? 0 : 3, lat, o_rsp_rdata, o_rsp_err, e.rdata, e.err);
  endtask

  task automatic txn(input logic w, input logic [63:0] a, input logic [1:0] sz,
                     input logic u, input logic [63:0] wd,
                     input logic [63:0] er, input logic ee, input int hold);
    bit ok;
    start_req(w, a, sz, u, wd, er, ee, ok);
    if (ok) finish_rsp(hold);
  endtask

  initial begin
    bit ok;
    exp_t dropped;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    chk("rst_rdata", o_rsp_rdata, 64'd0);
    chk("rst_err", {63'd0, o_rsp_err}, 64'd0);
    reset = 1'b0;

    // Double store/load, byte merge, byte extension
    txn(1, 64'h10, 2'd3, 0, 64'h1122334455667788, 64'd0, 0, 0);
    txn(0, 64'h10, 2'd3, 0, 64'd0, 64'h1122334455667788, 0, 0);
    txn(1, 64'h13, 2'd0, 0, 64'hFFFFFFFFFFFFFFAB, 64'd0, 0, 0);
    txn(0, 64'h10, 2'd3, 0, 64'd0, 64'h11223344AB667788, 0, 5);
    txn(0, 64'h13, 2'd0, 0, 64'd0, 64'hFFFFFFFFFFFFFFAB, 0, 0);
    txn(0, 64'h13, 2'd0, 1, 64'd0, 64'h00000000000000AB, 0, 0);

    // Word and half extension
    txn(1, 64'h20, 2'd2, 0, 64'hCAFEBABE80000001, 64'd0, 0, 0);
    txn(0, 64'h20, 2'd2, 0, 64'd0, 64'hFFFFFFFF80000001, 0, 0);
    txn(0, 64'h20, 2'd2, 1, 64'd0, 64'h0000000080000001, 0, 0);
    txn(1, 64'h26, 2'd1, 0, 64'h123456787FFF, 64'd0, 0, 0);
    txn(0, 64'h26, 2'd1, 0, 64'd0, 64'h0000000000007FFF, 0, 0);
    txn(0, 64'h20, 2'd2, 1, 64'd0, 64'h0000000080000001, 0, 0);

    // Misaligned and out-of-range accesses
    txn(0, 64'h22, 2'd2, 0, 64'd0, 64'd0, 1, 0);
    txn(1, 64'h7F8, 2'd3, 0, 64'h0123456789ABCDEF, 64'd0, 0, 0);
    txn(1, 64'h800, 2'd3, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0);
    txn(1, 64'h7FC, 2'd3, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0);
    txn(0, 64'h7F8, 2'd3, 0, 64'd0, 64'h0123456789ABCDEF, 0, 0);

    // Reset during WAIT must drop the pending store
    txn(1, 64'h30, 2'd3, 0, 64'd0, 64'd0, 0, 0);
    txn(0, 64'h10, 2'd3, 0, 64'd0, 64'h11223344AB667788, 0, 0);
    start_req(1, 64'h30, 2'd3, 0, 64'hDEAD, 64'd0, 0, ok);
    if (ok) begin
      dropped = sb_q.pop_front();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_req_ready", {63'd0, o_req_ready}, 64'd1);
      chk("midrst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
      chk("midrst_rdata", o_rsp_rdata, 64'd0);
      chk("midrst_err", {63'd0, o_rsp_err}, 64'd0);
      reset = 1'b0;
      $display("[TB] txn dut=3 reset during WAIT, response for %h dropped", dropped.rdata);
    end
    txn(0, 64'h30, 2'd3, 0, 64'd0, 64'd0, 0, 0);

    // Zero-wait responder
    sel = 1'b1;
    txn(1, 64'h40, 2'd3, 0, 64'h8877665544332255, 64'd0, 0, 0);
    txn(0, 64'h40, 2'd0, 0, 64'd0, 64'h0000000000000055, 0, 2);
    txn(0, 64'h46, 2'd1, 0, 64'd0, 64'hFFFFFFFFFFFF8877, 0, 0);
    txn(0, 64'h41, 2'd1, 0, 64'd0, 64'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
